// File: rtl/gpio_seq_ctrl.sv
// rtl/gpio_seq_ctrl.sv - bus-mapped sequencer stepping a GPIO output word through timed patterns
//
// Purpose: software loads up to DEPTH (pattern, hold) steps, a step count and a
// repeat count over the 8-bit register bus, issues START and polls DONE. While
// running, step i drives PATTERN[i] on SEQ_OUT for HOLD[i]+1 cycles.
//
// Ports:
//   BUS_CLK   in     1   single clock
//   BUS_RST   in     1   synchronous active-high reset
//   BUS_ADD   in     16  bus address
//   BUS_DATA  inout  8   bus data, driven by this block one cycle after a read strobe
//   BUS_RD    in     1   read strobe
//   BUS_WR    in     1   write strobe
//   SEQ_TRIG  in     1   external launch trigger (only with GPIO_SEQ_EXT_TRIG_EN)
//   SEQ_OUT   out    8   sequenced output word
//   SEQ_BUSY  out    1   high while a sequence runs
//   SEQ_STEP  out    3   active step index
//
// Optional feature macro: GPIO_SEQ_EXT_TRIG_EN (external armed trigger).

module gpio_seq_ctrl #(
   parameter logic [15:0] BASEADDR = 16'h0000,
   parameter logic [15:0] HIGHADDR = 16'h001f,
   parameter int          DEPTH    = 8,
   parameter logic [7:0]  VERSION  = 8'd1
) (
   input  logic        BUS_CLK,
   input  logic        BUS_RST,
   input  logic [15:0] BUS_ADD,
   inout  wire  [7:0]  BUS_DATA,
   input  logic        BUS_RD,
   input  logic        BUS_WR,
`ifdef GPIO_SEQ_EXT_TRIG_EN
   input  logic        SEQ_TRIG,
`endif
   output logic [7:0]  SEQ_OUT,
   output logic        SEQ_BUSY,
   output logic [2:0]  SEQ_STEP
);

   localparam logic [3:0] DEPTH_W = 4'(DEPTH);

   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t state_q, state_d;

   logic [15:0] rel;
   logic [4:0]  off;
   logic [2:0]  slot;
   logic        in_range, wr_hit, rd_hit, soft_rst;
   logic        start_cmd, stop_cmd, go, pat_slot;
   logic [3:0]  nsteps_wr;

   logic [3:0]  nsteps_q;
   logic [7:0]  repeat_q, idle_q;
   logic [7:0]  pattern_q [8];
   logic [7:0]  hold_q    [8];

   logic [2:0]  step_q, step_d, step_inc;
   logic [7:0]  cnt_q, cnt_d, rep_q, rep_d, pat_q, pat_d;
   logic [3:0]  run_n_q, run_n_d;
   logic        forever_q, forever_d, done_q, done_d, last_step;

   logic [7:0]  rd_data_q, rd_mux;
   logic        rd_valid_q, arm_rd;

   // Address decode; the upper-bit test rejects addresses below BASEADDR (they wrap)
   assign rel       = BUS_ADD - BASEADDR;
   assign in_range  = (rel[15:5] == 11'd0) && (BUS_ADD <= HIGHADDR);
   assign off       = rel[4:0];
   assign slot      = off[3:1];
   assign wr_hit    = BUS_WR && in_range;
   assign rd_hit    = BUS_RD && in_range;
   assign soft_rst  = BUS_RST || (wr_hit && off == 5'd0);
   assign start_cmd = wr_hit && off == 5'd1 && BUS_DATA[0];
   assign stop_cmd  = wr_hit && off == 5'd4;
   assign pat_slot  = off[4] && ({1'b0, slot} < DEPTH_W);
   assign nsteps_wr = (BUS_DATA[3:0] == 4'd0 || BUS_DATA[3:0] > DEPTH_W) ? DEPTH_W : BUS_DATA[3:0];

   always_ff @(posedge BUS_CLK) begin
      if (soft_rst) begin
         nsteps_q <= 4'd1;
         repeat_q <= 8'd1;
         idle_q   <= 8'd0;
         for (int i = 0; i < 8; i++) begin
            pattern_q[i] <= 8'd0;
            hold_q[i]    <= 8'd0;
         end
      end else if (wr_hit) begin
         case (off)
            5'd2:    nsteps_q <= nsteps_wr;
            5'd3:    repeat_q <= BUS_DATA;
            5'd5:    idle_q   <= BUS_DATA;
            default: begin
               if (pat_slot) begin
                  if (off[0]) hold_q[slot]    <= BUS_DATA;
                  else        pattern_q[slot] <= BUS_DATA;
               end
            end
         endcase
      end
   end

`ifdef GPIO_SEQ_EXT_TRIG_EN
   logic [2:0] trig_sync_q;
   logic       arm_q, trig_start;

   // Two flops synchronise SEQ_TRIG, the third holds the previous level for edge detect
   assign trig_start = trig_sync_q[1] && !trig_sync_q[2] && arm_q && (state_q == S_IDLE);

   always_ff @(posedge BUS_CLK) begin
      if (soft_rst) begin
         trig_sync_q <= 3'd0;
         arm_q       <= 1'b0;
      end else begin
         trig_sync_q <= {trig_sync_q[1:0], SEQ_TRIG};
         if (wr_hit && off == 5'd1) arm_q <= BUS_DATA[1];
         else if (trig_start)       arm_q <= 1'b0;
      end
   end

   assign go     = start_cmd || trig_start;
   assign arm_rd = arm_q;
`else
   assign go     = start_cmd;
   assign arm_rd = 1'b0;
`endif

   assign step_inc  = step_q + 3'd1;
   assign last_step = ({1'b0, step_q} + 4'd1) == run_n_q;

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      cnt_d     = cnt_q;
      rep_d     = rep_q;
      pat_d     = pat_q;
      run_n_d   = run_n_q;
      forever_d = forever_q;
      done_d    = done_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d   = S_RUN;
               step_d    = 3'd0;
               cnt_d     = hold_q[0];
               pat_d     = pattern_q[0];
               rep_d     = repeat_q;
               forever_d = (repeat_q == 8'd0);
               run_n_d   = nsteps_q;
               done_d    = 1'b0;
            end
         end
         S_RUN: begin
            if (stop_cmd) begin
               state_d = S_IDLE;
               step_d  = 3'd0;
            end else if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (!last_step) begin
               step_d = step_inc;
               cnt_d  = hold_q[step_inc];
               pat_d  = pattern_q[step_inc];
            end else if (!forever_q && rep_q == 8'd1) begin
               state_d = S_IDLE;
               step_d  = 3'd0;
               done_d  = 1'b1;
            end else begin
               // Wrap to step 0; the counter is meaningless when looping forever
               if (!forever_q) rep_d = rep_q - 8'd1;
               step_d = 3'd0;
               cnt_d  = hold_q[0];
               pat_d  = pattern_q[0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (soft_rst) begin
         state_q   <= S_IDLE;
         step_q    <= 3'd0;
         cnt_q     <= 8'd0;
         rep_q     <= 8'd0;
         pat_q     <= 8'd0;
         run_n_q   <= 4'd1;
         forever_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         cnt_q     <= cnt_d;
         rep_q     <= rep_d;
         pat_q     <= pat_d;
         run_n_q   <= run_n_d;
         forever_q <= forever_d;
         done_q    <= done_d;
      end
   end

   assign SEQ_OUT  = (state_q == S_RUN) ? pat_q : idle_q;
   assign SEQ_BUSY = (state_q == S_RUN);
   assign SEQ_STEP = step_q;

   always_comb begin
      rd_mux = 8'd0;
      case (off)
         5'd0:    rd_mux = VERSION;
         5'd1:    rd_mux = {5'd0, arm_rd, SEQ_BUSY, done_q};
         5'd2:    rd_mux = {4'd0, nsteps_q};
         5'd3:    rd_mux = repeat_q;
         5'd5:    rd_mux = idle_q;
         default: begin
            if (pat_slot) rd_mux = off[0] ? hold_q[slot] : pattern_q[slot];
         end
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (soft_rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'd0;
      end else begin
         rd_valid_q <= rd_hit;
         rd_data_q  <= rd_mux;
      end
   end

   assign BUS_DATA = rd_valid_q ? rd_data_q : 8'bz;

endmodule
